// File: rtl/zeroriscy_multdiv_iter_pkg.sv
// Shared types for the iterative multiply/divide unit.
// Operator and state encodings plus the divide-by-zero quotient.
package zeroriscy_defines;

  typedef enum logic [1:0] {
    MD_OP_MULL = 2'd0,
    MD_OP_MULH = 2'd1,
    MD_OP_DIV  = 2'd2,
    MD_OP_REM  = 2'd3
  } md_op_e;

  typedef enum logic [2:0] {
    MD_IDLE,
    MD_ABS_A,
    MD_ABS_B,
    MD_COMP,
    MD_SIGN,
    MD_DONE
  } md_state_e;

  localparam logic [63:0] MD_DIV_ZERO_Q = '1;

  function automatic logic md_is_div(md_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/zeroriscy_multdiv_adder.sv
// WIDTH+2 bit adder with carry-in shared by all multdiv arithmetic.
// Ports: a, b operands; cin carry-in; sum result (carry-out dropped).
module zeroriscy_multdiv_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH+1:0] a,
  input  logic [WIDTH+1:0] b,
  input  logic             cin,
  output logic [WIDTH+1:0] sum
);

  assign sum = a + b + {{(WIDTH+1){1'b0}}, cin};

endmodule

// File: rtl/zeroriscy_multdiv_iter.sv
// Iterative RV32M multiply/divide unit with its own adder.
// Ports: valid_i/ready_o request side, valid_o/ready_i result side,
// operator_i, signed_mode_i, op_a_i, op_b_i, kill_i, result_o.
module zeroriscy_multdiv_iter
  import zeroriscy_defines::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  output logic             ready_o,
  input  md_op_e           operator_i,
  input  logic [1:0]       signed_mode_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             kill_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o
);

  localparam int AW = WIDTH + 2;

  md_state_e        state;
  md_op_e           op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] low_q;
  logic [WIDTH:0]   acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sign_a;
  logic             sign_b;
  logic             b_signed_q;

  logic [AW-1:0]    add_x;
  logic [AW-1:0]    add_y;
  logic [AW-1:0]    sum;
  logic             add_cin;

  logic             last;
  logic             is_div;
  logic             mul_neg;
  logic             sgn_neg;
  logic [WIDTH-1:0] sgn_val;
  logic [AW-1:0]    a_sx;

  assign last    = (cnt_q == '0);
  assign is_div  = md_is_div(op_q);
  // MSB of a signed multiplier carries negative weight
  assign mul_neg = last & b_signed_q;
  assign a_sx    = {{2{sign_a}}, a_q};
  assign sgn_neg = (op_q == MD_OP_DIV) ? (sign_a ^ sign_b) : sign_a;
  assign sgn_val = (op_q == MD_OP_DIV) ? low_q : acc_q[WIDTH-1:0];

  zeroriscy_multdiv_adder #(
    .WIDTH(WIDTH)
  ) u_adder (
    .a  (add_x),
    .b  (add_y),
    .cin(add_cin),
    .sum(sum)
  );

  always_comb begin
    add_x   = '0;
    add_y   = '0;
    add_cin = 1'b0;
    unique case (state)
      MD_ABS_A: begin
        add_y   = {2'b00, sign_a ? ~a_q : a_q};
        add_cin = sign_a;
      end
      MD_ABS_B: begin
        add_y   = {2'b00, sign_b ? ~b_q : b_q};
        add_cin = sign_b;
      end
      MD_COMP: begin
        if (is_div) begin
          // trial subtract of divisor from shifted remainder
          add_x   = {1'b0, acc_q[WIDTH-1:0], low_q[WIDTH-1]};
          add_y   = ~{2'b00, b_q};
          add_cin = 1'b1;
        end else begin
          add_x = {acc_q[WIDTH], acc_q};
          if (b_q[0]) begin
            add_y   = mul_neg ? ~a_sx : a_sx;
            add_cin = mul_neg;
          end
        end
      end
      MD_SIGN: begin
        add_y   = {2'b00, sgn_neg ? ~sgn_val : sgn_val};
        add_cin = sgn_neg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= MD_IDLE;
      op_q       <= MD_OP_MULL;
      a_q        <= '0;
      b_q        <= '0;
      low_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      sign_a     <= 1'b0;
      sign_b     <= 1'b0;
      b_signed_q <= 1'b0;
      ready_o    <= 1'b1;
      valid_o    <= 1'b0;
      result_o   <= '0;
    end else if (state != MD_IDLE && kill_i) begin
      state   <= MD_IDLE;
      ready_o <= 1'b1;
      valid_o <= 1'b0;
    end else begin
      unique case (state)
        MD_IDLE: begin
          if (valid_i) begin
            op_q       <= operator_i;
            a_q        <= op_a_i;
            b_q        <= op_b_i;
            acc_q      <= '0;
            low_q      <= '0;
            sign_a     <= signed_mode_i[0] & op_a_i[WIDTH-1];
            sign_b     <= signed_mode_i[1] & op_b_i[WIDTH-1];
            b_signed_q <= signed_mode_i[1];
            ready_o    <= 1'b0;
            if (md_is_div(operator_i) && op_b_i == '0) begin
              state    <= MD_DONE;
              valid_o  <= 1'b1;
              result_o <= (operator_i == MD_OP_DIV) ?
                          MD_DIV_ZERO_Q[WIDTH-1:0] : op_a_i;
            end else if (md_is_div(operator_i)) begin
              state <= MD_ABS_A;
            end else begin
              state <= MD_COMP;
              cnt_q <= CNT_W'(WIDTH - 1);
            end
          end
        end
        MD_ABS_A: begin
          low_q <= sum[WIDTH-1:0];
          state <= MD_ABS_B;
        end
        MD_ABS_B: begin
          b_q   <= sum[WIDTH-1:0];
          cnt_q <= CNT_W'(WIDTH - 1);
          state <= MD_COMP;
        end
        MD_COMP: begin
          if (!last) cnt_q <= cnt_q - 1'b1;
          if (is_div) begin
            if (!sum[AW-1]) begin
              acc_q <= sum[WIDTH:0];
              low_q <= {low_q[WIDTH-2:0], 1'b1};
            end else begin
              acc_q <= {acc_q[WIDTH-1:0], low_q[WIDTH-1]};
              low_q <= {low_q[WIDTH-2:0], 1'b0};
            end
            if (last) state <= MD_SIGN;
          end else begin
            acc_q <= sum[AW-1:1];
            low_q <= {sum[0], low_q[WIDTH-1:1]};
            b_q   <= b_q >> 1;
            if (last) begin
              state    <= MD_DONE;
              valid_o  <= 1'b1;
              result_o <= (op_q == MD_OP_MULL) ?
                          {sum[0], low_q[WIDTH-1:1]} : sum[WIDTH:1];
            end
          end
        end
        MD_SIGN: begin
          result_o <= sum[WIDTH-1:0];
          valid_o  <= 1'b1;
          state    <= MD_DONE;
        end
        MD_DONE: begin
          if (ready_i) begin
            state   <= MD_IDLE;
            valid_o <= 1'b0;
            ready_o <= 1'b1;
          end
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: doc/zeroriscy_multdiv_iter.md
# zeroriscy_multdiv_iter

Parametrised, self-contained iterative multiply/divide unit for the zero-riscy execute stage. It is the successor to the ALU-sharing slow multiplier/divider. Operand width is generic, and the unit has its own internal adder, so the ALU is not borrowed. It uses a valid/ready handshake on both sides, can be killed mid-operation, and holds its result until the consumer accepts it. It implements full RISC-V M semantics (MUL, MULH/HSU/HU, DIV/U, REM/U), including divide-by-zero and signed-overflow cases.

## Interface
- WIDTH, 32: operand and result width; any value 4..64.
- CNT_W, $clog2(WIDTH): iteration counter width; derived, do not override.
- clk  in  1  clock.
- rst_n  in  1  reset: asynchronous, active-low.
- valid_i  in  1  request valid; sampled only while ready_o=1.
- ready_o  out  1  unit idle and able to accept a request.
- operator_i  in  2  md_op_e: MD_OP_MULL=0, MD_OP_MULH=1, MD_OP_DIV=2, MD_OP_REM=3.
- signed_mode_i  in  2  bit0: op_a signed; bit1: op_b signed.
- op_a_i  in  WIDTH  multiplicand or dividend.
- op_b_i  in  WIDTH  multiplier or divisor.
- kill_i  in  1  abort the current operation; ignored while idle.
- valid_o  out  1  result_o valid.
- ready_i  in  1  consumer accepts the result.
- result_o  out  WIDTH  result; stable while valid_o=1 and ready_i=0.

## Operation
- Request capture: a request is accepted when valid_i & ready_o. Operands, operator_i and signed_mode_i are registered at acceptance; later changes on the inputs have no effect.
- States (md_state_e): MD_IDLE, MD_ABS_A, MD_ABS_B, MD_COMP, MD_SIGN, MD_DONE.
- MULL/MULH transitions: IDLE -> COMP for WIDTH cycles -> DONE.
  - Baugh-Wooley shift-add, one op_b bit per cycle, LSB first.
  - Accumulator is WIDTH+1 bits; operands are sign-extended to WIDTH+1 bits per signed_mode.
  - MULL returns product[WIDTH-1:0]; MULH returns product[2*WIDTH-1:WIDTH].
- DIV/REM transitions: IDLE -> ABS_A -> ABS_B -> COMP for WIDTH cycles -> SIGN -> DONE.
  - Restoring long division on absolute values, one quotient bit per cycle, MSB first.
  - SIGN negates the quotient when sign_a^sign_b, and negates the remainder when sign_a.
- Divide by zero (op_b=0, checked in IDLE): IDLE -> DONE directly. DIV returns all-ones; REM returns op_a.
- Signed overflow (op_a=MIN, op_b=-1, both signed): handled by the normal path. Required results are quotient=MIN and remainder=0, with no trap.
- Iteration counter: loads WIDTH-1 on entry to COMP and decrements each COMP cycle. COMP exits when the counter equals 0.
- DONE: valid_o=1. DONE -> IDLE on ready_i.
- kill_i in any non-IDLE state: next state is IDLE, valid_o drops next cycle, and no result is delivered. This includes DONE with ready_i=0.
- kill_i and ready_i together in DONE: kill wins, but the result is treated as consumed either way.

## Timing
- Reset values: ready_o=1, valid_o=0, result_o=0, state=MD_IDLE, counter=0, all datapath registers 0.
- Latency, measured from the accept edge to the first cycle with valid_o=1:
  - MUL: WIDTH+1 cycles.
  - DIV/REM: WIDTH+4 cycles.
  - Divide by zero: 1 cycle.
- Throughput: back-to-back operation is allowed. The DONE cycle with ready_i=1 returns to IDLE, and the next request is accepted one cycle later. No request is accepted in the same cycle as DONE.
- ready_o is a registered decode of state==MD_IDLE only; it has no combinational path from any input.
- valid_o and result_o are registered.
- Reset asserted mid-operation clears the unit immediately (asynchronous reset); the result is lost.

## Structure
- zeroriscy_defines package holds:
  - md_op_e, already present, reused.
  - New md_state_e enum.
  - New constant MD_DIV_ZERO_Q='1.
- Sub-module zeroriscy_multdiv_adder: a WIDTH+2-bit adder with carry-in, used for the shift-add accumulate, the trial subtract and the negations. It is instantiated once.
- Everything else (FSM, counter, shift registers, sign logic) lives in the top module.

## Test plan
- WIDTH=32, MULL 0x0000_0007 × 0xFFFF_FFFD, signed -> result 0xFFFF_FFEB after 33 cycles.
- MULH signed 0x8000_0000 × 0x8000_0000 -> 0x4000_0000. MULHU 0xFFFF_FFFF × 0xFFFF_FFFF -> 0xFFFF_FFFE.
- DIV signed -7/2 -> 0xFFFF_FFFD, and REM -> 0xFFFF_FFFF, each after 36 cycles. DIVU 100/7 -> 14, and REMU -> 2.
- DIV x/0 -> 0xFFFF_FFFF and REM 0x1234/0 -> 0x1234, each with valid_o one cycle after accept. Signed DIV 0x8000_0000/-1 -> 0x8000_0000, and REM -> 0.
- Hold ready_i=0 for 5 cycles in DONE -> result_o stable and valid_o held. Then a new request issued 1 cycle after acceptance completes correctly.
- kill_i at COMP cycle 10 -> IDLE next cycle with valid_o never asserted. Repeat at WIDTH=8 (MULL 0x0F×0x11 -> 0xFF) and WIDTH=16.
